conv1_weight_buffer: RTL and testbench
======================================

CONV1_WEIGHT_BUFFER -- requirements
Module: conv1_weight_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, width of one weight-FIFO word.
REQ-002 SHALL have parameter W_WIDTH, default 8, width of one signed weight.
REQ-003 SHALL have parameter KWORDS, default 4, FIFO words per output-channel kernel (27 weights zero-padded to 32).
REQ-004 SHALL have parameter OC_NUM, default 64, number of output-channel kernels per weight pass.
REQ-005 SHALL have port s_clk  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port s_rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port i_weight_in  input  DATA_WIDTH  FIFO read data, valid one cycle after the strobe.
REQ-008 SHALL have port i_weight_valid  input  1  FIFO read strobe from the upstream weight store.
REQ-009 SHALL have port o_weight_ready  output  1  request for one more FIFO word.
REQ-010 SHALL have port o_load_w_finish  output  1  one-cycle pulse after the last word of kernel OC_NUM-1 is captured.
REQ-011 SHALL have port o_kernel  output  KWORDS*DATA_WIDTH  active kernel; word k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have port o_kernel_valid  output  1  o_kernel holds an unconsumed kernel.
REQ-013 SHALL have port o_oc_index  output  clog2(OC_NUM)  output-channel index of o_kernel.
REQ-014 SHALL have port i_kernel_consume  input  1  PE-array pulse: current kernel used, release it.

Function
REQ-015 SHALL hold two banks: a shadow bank (fill side) and an active bank (drives o_kernel).
REQ-016 Fill FSM SHALL use states FILL and HOLD; FILL -> HOLD when the KWORDS-th word is captured; HOLD -> FILL on the cycle the shadow bank is swapped into the active bank.
REQ-017 o_weight_ready SHALL be registered and high only in FILL while issued strobes (req_cnt) < KWORDS.
REQ-018 Each i_weight_valid while o_weight_ready=1 SHALL increment req_cnt.
REQ-019 The block SHALL capture i_weight_in into shadow word wr_cnt on the cycle after each accepted strobe, then increment wr_cnt.
REQ-020 A strobe arriving while o_weight_ready=0 SHALL be ignored: no count change, and its data is not captured.
REQ-021 A swap SHALL occur on the edge where the FSM is in HOLD and (o_kernel_valid=0 or i_kernel_consume=1).
REQ-022 On swap: o_kernel <= shadow; o_kernel_valid <= 1; o_oc_index <= shadow channel index; req_cnt and wr_cnt <= 0.
REQ-023 i_kernel_consume with no swap possible SHALL clear o_kernel_valid; o_kernel retains its value.
REQ-024 i_kernel_consume while o_kernel_valid=0 SHALL be ignored.
REQ-025 A kernel completing on the same edge as a consume SHALL NOT swap that edge; it swaps on the next edge, leaving one cycle with o_kernel_valid=0.
REQ-026 The shadow channel index SHALL increment per completed kernel and wrap from OC_NUM-1 to 0.
REQ-027 o_load_w_finish SHALL pulse for exactly one cycle, one cycle after the final capture of channel OC_NUM-1.
REQ-028 After that pulse, filling SHALL continue with channel 0; words already prefetched upstream are flushed by the upstream store, so no extra words arrive.
REQ-029 Counters SHALL be clog2(KWORDS)+1 bits wide; weights SHALL pass through unmodified, with no sign or bit manipulation.

Reset
REQ-030 While s_rst=1, the block SHALL hold: o_weight_ready=0, o_load_w_finish=0, o_kernel_valid=0, o_kernel=0, o_oc_index=0, all counters 0, FSM=FILL, both banks 0.
REQ-031 The first edge after s_rst falls SHALL set o_weight_ready=1.
REQ-032 Reset mid-fill SHALL discard partial shadow contents; fetching restarts at channel 0.

Verification
REQ-033 Reset release, then 4 strobes with data 0x11..,0x22..,0x33..,0x44.. one cycle later -> o_kernel_valid=1 with o_kernel[63:0]=0x11..., o_kernel[255:192]=0x44..., o_oc_index=0; o_weight_ready drops after the 4th strobe and refills channel 1.
REQ-034 PE never consumes -> channel 1 shadow fills; FSM stays in HOLD; o_weight_ready=0; o_kernel unchanged; extra strobes ignored.
REQ-035 Consume pulse with shadow full -> next edge o_oc_index=1 with new data, o_kernel_valid stays 1, o_weight_ready reasserts.
REQ-036 OC_NUM=4, continuous strobes and consumes -> o_load_w_finish pulses once, one cycle after the 16th capture; o_oc_index sequence is 0,1,2,3,0.
REQ-037 s_rst asserted after 2 of 4 words, then 4 fresh words -> the kernel contains only the fresh words, and o_oc_index=0.
REQ-038 Consume on the same edge as the 4th capture -> o_kernel_valid=0 for exactly one cycle, then 1 with the next channel.

Source files
------------

// File: rtl/conv1_weight_buffer.sv
// Double-buffered conv1 kernel store: fills a shadow bank from the weight FIFO and swaps it into the active bank.
// Word captured one cycle after its strobe; fetching stalls (o_weight_ready=0) while a full shadow waits for the PE array.
module conv1_weight_buffer #(
    parameter int DATA_WIDTH = 64,
    parameter int W_WIDTH    = 8,
    parameter int KWORDS     = 4,
    parameter int OC_NUM     = 64,
    localparam int OCW       = (OC_NUM > 1) ? $clog2(OC_NUM) : 1
) (
    input  logic                         s_clk,
    input  logic                         s_rst,
    input  logic [DATA_WIDTH-1:0]        i_weight_in,
    input  logic                         i_weight_valid,
    output logic                         o_weight_ready,
    output logic                         o_load_w_finish,
    output logic [KWORDS*DATA_WIDTH-1:0] o_kernel,
    output logic                         o_kernel_valid,
    output logic [OCW-1:0]               o_oc_index,
    input  logic                         i_kernel_consume
);

    localparam int CW    = $clog2(KWORDS) + 1;
    localparam int IW    = (KWORDS > 1) ? $clog2(KWORDS) : 1;
    localparam int LANES = DATA_WIDTH / W_WIDTH;

    typedef enum logic {FILL, HOLD} state_t;

    state_t                         r_state;
    logic [CW-1:0]                  r_req_cnt;
    logic [CW-1:0]                  r_wr_cnt;
    logic                           r_weight_ready;
    logic                           r_cap_pend;
    logic                           r_load_w_finish;
    logic [DATA_WIDTH-1:0]          r_shadow [KWORDS];
    logic [OCW-1:0]                 r_shadow_oc;
    logic [KWORDS*DATA_WIDTH-1:0]   r_kernel;
    logic                           r_kernel_valid;
    logic [OCW-1:0]                 r_oc_index;

    logic [DATA_WIDTH-1:0]          w_word;
    logic [KWORDS*DATA_WIDTH-1:0]   w_shadow_flat;
    logic                           w_accept;
    logic                           w_last_cap;
    logic                           w_swap;
    logic [CW-1:0]                  w_req_nxt;
    state_t                         w_state_nxt;

    // Weights are moved lane by lane as opaque signed bytes; nothing is reinterpreted.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_word[l*W_WIDTH +: W_WIDTH] = i_weight_in[l*W_WIDTH +: W_WIDTH];
    end

    for (genvar k = 0; k < KWORDS; k++) begin : g_flat
        assign w_shadow_flat[k*DATA_WIDTH +: DATA_WIDTH] = r_shadow[k];
    end

    assign w_accept    = i_weight_valid & r_weight_ready;
    assign w_last_cap  = r_cap_pend && (r_wr_cnt == CW'(KWORDS - 1));
    assign w_swap      = (r_state == HOLD) && (!r_kernel_valid || i_kernel_consume);
    assign w_req_nxt   = w_swap ? '0 : r_req_cnt + CW'(w_accept);
    assign w_state_nxt = w_swap ? FILL : (w_last_cap ? HOLD : r_state);

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            r_state         <= FILL;
            r_req_cnt       <= '0;
            r_wr_cnt        <= '0;
            r_weight_ready  <= 1'b0;
            r_cap_pend      <= 1'b0;
            r_load_w_finish <= 1'b0;
            r_shadow_oc     <= '0;
            r_kernel        <= '0;
            r_kernel_valid  <= 1'b0;
            r_oc_index      <= '0;
            for (int k = 0; k < KWORDS; k++) begin
                r_shadow[k] <= '0;
            end
        end else begin
            r_state         <= w_state_nxt;
            r_req_cnt       <= w_req_nxt;
            r_weight_ready  <= (w_state_nxt == FILL) && (w_req_nxt < CW'(KWORDS));
            r_cap_pend      <= w_accept;
            r_load_w_finish <= w_last_cap && (r_shadow_oc == OCW'(OC_NUM - 1));

            if (r_cap_pend) begin
                r_shadow[r_wr_cnt[IW-1:0]] <= w_word;
                r_wr_cnt                   <= r_wr_cnt + CW'(1);
            end

            // Swap and capture are exclusive: no strobe is accepted while in HOLD.
            if (w_swap) begin
                r_kernel       <= w_shadow_flat;
                r_kernel_valid <= 1'b1;
                r_oc_index     <= r_shadow_oc;
                r_shadow_oc    <= (r_shadow_oc == OCW'(OC_NUM - 1)) ? '0 : r_shadow_oc + OCW'(1);
                r_wr_cnt       <= '0;
            end else if (i_kernel_consume) begin
                r_kernel_valid <= 1'b0;
            end
        end
    end

    assign o_weight_ready  = r_weight_ready;
    assign o_load_w_finish = r_load_w_finish;
    assign o_kernel        = r_kernel;
    assign o_kernel_valid  = r_kernel_valid;
    assign o_oc_index      = r_oc_index;

endmodule

// File: tb/tb_conv1_weight_buffer.sv
// Bench for conv1_weight_buffer: directed scenarios plus random traffic against a queue-based kernel model.
module tb_conv1_weight_buffer;

    localparam int DW  = 64;
    localparam int KW  = 4;
    localparam int OCN = 4;
    localparam int OCW = 2;

    logic                 s_clk = 1'b0;
    logic                 s_rst;
    logic [DW-1:0]        i_weight_in;
    logic                 i_weight_valid;
    logic                 o_weight_ready;
    logic                 o_load_w_finish;
    logic [KW*DW-1:0]     o_kernel;
    logic                 o_kernel_valid;
    logic [OCW-1:0]       o_oc_index;
    logic                 i_kernel_consume;

    always #5 s_clk = ~s_clk;

    conv1_weight_buffer #(
        .DATA_WIDTH(DW), .W_WIDTH(8), .KWORDS(KW), .OC_NUM(OCN)
    ) dut (
        .s_clk           (s_clk),
        .s_rst           (s_rst),
        .i_weight_in     (i_weight_in),
        .i_weight_valid  (i_weight_valid),
        .o_weight_ready  (o_weight_ready),
        .o_load_w_finish (o_load_w_finish),
        .o_kernel        (o_kernel),
        .o_kernel_valid  (o_kernel_valid),
        .o_oc_index      (o_oc_index),
        .i_kernel_consume(i_kernel_consume)
    );

    // Reference model: shadow is a queue of captured words, active kernel a packed vector.
    bit               m_fill, m_ready, m_pending, m_kvalid, m_finish;
    int               m_req, m_oc, m_shoc;
    logic [DW-1:0]    m_shadow [$];
    logic [KW*DW-1:0] m_kernel;
    logic [DW-1:0]    src_q [$];
    logic [DW-1:0]    fresh [KW];
    logic [KW*DW-1:0] fresh_flat;
    int               checks = 0;
    int               failures = 0;
    int               dut_fin = 0;
    int               mdl_fin = 0;

    function automatic void model_reset();
        m_fill = 1'b1; m_ready = 1'b0; m_pending = 1'b0; m_kvalid = 1'b0; m_finish = 1'b0;
        m_req = 0; m_oc = 0; m_shoc = 0;
        m_shadow.delete();
        m_kernel = '0;
    endfunction

    function automatic void model_step(input bit strobe, input bit consume, input logic [DW-1:0] data);
        bit swap;
        bit acc;
        swap = !m_fill && (!m_kvalid || consume);
        acc  = strobe && m_ready;
        m_finish = 1'b0;
        if (m_pending) begin
            m_shadow.push_back(data);
            if (m_shadow.size() == KW) begin
                m_fill   = 1'b0;
                m_finish = (m_shoc == OCN - 1);
            end
        end
        m_pending = acc;
        if (acc) m_req++;
        if (swap) begin
            for (int k = 0; k < KW; k++) m_kernel[k*DW +: DW] = m_shadow[k];
            m_kvalid = 1'b1;
            m_oc     = m_shoc;
            m_shoc   = (m_shoc + 1) % OCN;
            m_shadow.delete();
            m_req    = 0;
            m_fill   = 1'b1;
        end else if (consume) begin
            m_kvalid = 1'b0;
        end
        m_ready = m_fill && (m_req < KW);
    endfunction

    task automatic chk(input string tag, input logic [KW*DW-1:0] obs, input logic [KW*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("ready",  o_weight_ready,  m_ready);
        chk("kvalid", o_kernel_valid,  m_kvalid);
        chk("oc",     o_oc_index,      m_oc);
        chk("finish", o_load_w_finish, m_finish);
        chk("kernel", o_kernel,        m_kernel);
        if (o_load_w_finish) dut_fin++;
        if (m_finish) mdl_fin++;
    endtask

    // Upstream store: data appears the cycle after an accepted strobe, junk otherwise.
    task automatic tick(input bit strobe, input bit consume);
        logic [DW-1:0] d;
        if (m_pending && src_q.size() > 0) d = src_q.pop_front();
        else d = {$urandom, $urandom};
        i_weight_valid   = strobe;
        i_kernel_consume = consume;
        i_weight_in      = d;
        @(posedge s_clk);
        if (s_rst) model_reset();
        else model_step(strobe, consume, d);
        @(negedge s_clk);
        compare_all();
    endtask

    initial begin
        s_rst = 1'b1;
        i_weight_in = '0;
        i_weight_valid = 1'b0;
        i_kernel_consume = 1'b0;
        model_reset();
        repeat (2) @(negedge s_clk);
        compare_all();

        // First kernel with known words.
        s_rst = 1'b0;
        src_q = '{64'h1111111111111111, 64'h2222222222222222,
                  64'h3333333333333333, 64'h4444444444444444};
        tick(1'b0, 1'b0);
        repeat (4) tick(1'b1, 1'b0);
        repeat (3) tick(1'b0, 1'b0);
        chk("k0_word0", o_kernel[63:0],    64'h1111111111111111);
        chk("k0_word3", o_kernel[255:192], 64'h4444444444444444);
        chk("k0_oc",    o_oc_index,        0);
        chk("k0_valid", o_kernel_valid,    1);

        // No consume: shadow fills, further strobes ignored.
        repeat (12) tick(1'b1, 1'b0);
        chk("hold_ready", o_weight_ready, 0);
        chk("hold_oc",    o_oc_index,     0);
        chk("hold_word0", o_kernel[63:0], 64'h1111111111111111);

        // Consume with full shadow swaps immediately.
        tick(1'b0, 1'b1);
        chk("swap_oc",    o_oc_index,     1);
        chk("swap_valid", o_kernel_valid, 1);
        chk("swap_ready", o_weight_ready, 1);

        // Consume on the edge of the 4th capture leaves one invalid cycle.
        repeat (4) tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        chk("gap_valid0", o_kernel_valid, 0);
        tick(1'b0, 1'b0);
        chk("gap_valid1", o_kernel_valid, 1);
        chk("gap_oc",     o_oc_index,     2);

        // Reset after two captured words, then a fresh kernel.
        repeat (2) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        s_rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        repeat (2) tick(1'b0, 1'b0);
        s_rst = 1'b0;
        for (int k = 0; k < KW; k++) begin
            fresh[k] = {$urandom, $urandom};
            src_q.push_back(fresh[k]);
            fresh_flat[k*DW +: DW] = fresh[k];
        end
        tick(1'b0, 1'b0);
        repeat (4) tick(1'b1, 1'b0);
        repeat (3) tick(1'b0, 1'b0);
        chk("rst_kernel", o_kernel,   fresh_flat);
        chk("rst_oc",     o_oc_index, 0);

        // Continuous strobes and consumes across several channel wraps.
        repeat (120) tick(1'b1, 1'b1);
        // Random traffic.
        repeat (500) tick($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
        chk("finish_count", dut_fin, mdl_fin);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
